// File: rtl/dram_burst_responder_if.sv
// Command, write-data and read-return signals between a DRAM initiator and the burst responder.
interface dram_burst_responder_if;
  logic [31:0]  dram_address;
  logic         dram_rnw;
  logic         dram_cmd_en;
  logic         dram_ready;
  logic [143:0] dram_data_o;
  logic [17:0]  dram_byte_enable;
  logic [143:0] dram_data_i;
  logic         dram_data_valid;

  modport master (
    output dram_address, dram_rnw, dram_cmd_en, dram_data_o, dram_byte_enable,
    input  dram_ready, dram_data_i, dram_data_valid
  );

  modport slave (
    input  dram_address, dram_rnw, dram_cmd_en, dram_data_o, dram_byte_enable,
    output dram_ready, dram_data_i, dram_data_valid
  );
endinterface

// File: rtl/dram_burst_responder.sv
// Purpose: 2-beat burst DRAM model with byte-enabled writes and periodic refresh stalls.
// Latency: read beat 0 returns READ_LATENCY cycles after acceptance, beat 1 on the next cycle.
// Backpressure: dram_ready only in IDLE; read returns cannot be stalled by the initiator.
module dram_burst_responder #(
  parameter int ADDR_BITS      = 9,
  parameter int READ_LATENCY   = 4,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                  dram_clk,
  input  logic                  dram_reset,
  dram_burst_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int RC_W  = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int RL_W  = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam bit REF_EN = (REFRESH_PERIOD > 0);

  typedef enum logic [1:0] {IDLE, WR2, RD2, REFRESH} state_t;

  state_t state, state_nxt;

  logic [143:0]          mem [DEPTH];
  logic [ADDR_BITS-2:0]  cmd_burst;
  logic [ADDR_BITS-2:0]  burst_q;
  logic [RC_W-1:0]       ref_cnt;
  logic [RL_W-1:0]       ref_left;
  logic                  ref_due;
  logic                  ready;
  logic                  accept;
  logic                  enter_ref;
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic                  rd_vld;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [143:0]          rd_word;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [143:0]          pipe_dat [READ_LATENCY];
  logic                  out_vld;
  logic                  unused_addr_bits;

  // Address bit 0 and everything above the beat address alias away.
  assign cmd_burst        = bus.dram_address[ADDR_BITS-1:1];
  assign unused_addr_bits = ^{bus.dram_address[31:ADDR_BITS], bus.dram_address[0]};
  assign ref_due          = REF_EN && (ref_cnt == RC_MAX);

  always_ff @(posedge dram_clk) begin
    if (dram_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = bus.dram_cmd_en;
        if (accept)       state_nxt = bus.dram_rnw ? RD2 : WR2;
        else if (ref_due) state_nxt = REFRESH;
      end
      WR2, RD2: state_nxt = ref_due ? REFRESH : IDLE;
      REFRESH:  if (ref_left == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (dram_reset) begin
      ready     = 1'b0;
      accept    = 1'b0;
      state_nxt = IDLE;
    end
    enter_ref = (state_nxt == REFRESH) && (state != REFRESH);
  end

  // The counter saturates at the due point, which keeps a deferred refresh pending.
  always_ff @(posedge dram_clk) begin
    if (dram_reset) begin
      ref_cnt  <= '0;
      ref_left <= '0;
    end else if (enter_ref) begin
      ref_cnt  <= '0;
      ref_left <= RL_MAX;
    end else begin
      if (REF_EN && ref_cnt != RC_MAX) ref_cnt <= ref_cnt + 1'b1;
      if (state == REFRESH && ref_left != '0) ref_left <= ref_left - 1'b1;
    end
  end

  always_ff @(posedge dram_clk) begin
    if (accept) burst_q <= cmd_burst;
  end

  always_comb begin
    wr_en   = (accept && !bus.dram_rnw) || (state == WR2 && !dram_reset);
    wr_addr = (state == WR2) ? {burst_q, 1'b1} : {cmd_burst, 1'b0};
    rd_vld  = (accept && bus.dram_rnw) || (state == RD2 && !dram_reset);
    rd_addr = (state == RD2) ? {burst_q, 1'b1} : {cmd_burst, 1'b0};
    rd_word = mem[rd_addr];
  end

  always_ff @(posedge dram_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 18; i++) begin
        if (bus.dram_byte_enable[i]) mem[wr_addr][8*i +: 8] <= bus.dram_data_o[8*i +: 8];
      end
    end
  end

  // Fixed-latency return pipe; beats are sampled at issue so later writes cannot disturb them.
  always_ff @(posedge dram_clk) begin
    if (dram_reset) pipe_vld <= '0;
    else            pipe_vld <= {pipe_vld[READ_LATENCY-2:0], rd_vld};
  end

  always_ff @(posedge dram_clk) begin
    pipe_dat[0] <= rd_word;
    for (int i = 1; i < READ_LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  assign out_vld             = pipe_vld[READ_LATENCY-1] && !dram_reset;
  assign bus.dram_ready      = ready;
  assign bus.dram_data_valid = out_vld;
  assign bus.dram_data_i     = out_vld ? pipe_dat[READ_LATENCY-1] : '0;
endmodule

// File: tb/tb_dram_burst_responder.sv
// Directed and randomized bench for dram_burst_responder against a cycle-timeline reference model.
module tb_dram_burst_responder;
  localparam int AB  = 9;
  localparam int LAT = 4;
  localparam int RP  = 16;
  localparam int RCY = 4;

  logic dram_clk   = 1'b0;
  logic dram_reset = 1'b1;
  always #5 dram_clk = ~dram_clk;

  dram_burst_responder_if bus ();

  dram_burst_responder #(
    .ADDR_BITS(AB), .READ_LATENCY(LAT), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RCY)
  ) dut (
    .dram_clk(dram_clk),
    .dram_reset(dram_reset),
    .bus(bus)
  );

  // Reference model: memory image, expected return per cycle, and the cycle the block is free again.
  logic [143:0] mem_m [1 << AB];
  logic [143:0] exp_dat [int];
  logic         obs_rdy [int];
  logic         obs_vld [int];
  logic [143:0] obs_dat [int];
  int cyc = 0, busy_until = 0, due_at = 0, n_cmp = 0, n_bad = 0;
  bit wr2_pend = 1'b0;
  int wr2_idx = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [143:0] rnd144();
    logic [159:0] x;
    x = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return x[143:0];
  endfunction

  task automatic merge(input int idx, input logic [143:0] d, input logic [17:0] be);
    for (int i = 0; i < 18; i++) if (be[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic tick(input bit rst, input bit en, input bit rnw, input logic [31:0] addr,
                      input logic [143:0] d, input logic [17:0] be, output bit acc);
    bit m_rdy, ev;
    logic [143:0] e;
    int idx0;
    @(negedge dram_clk);
    dram_reset           = rst;
    bus.dram_cmd_en      = en;
    bus.dram_rnw         = rnw;
    bus.dram_address     = addr;
    bus.dram_data_o      = d;
    bus.dram_byte_enable = be;
    #1;
    m_rdy = !rst && (cyc >= busy_until);
    ev = (exp_dat.exists(cyc) != 0);
    e = '0;
    if (ev) e = exp_dat[cyc];
    obs_rdy[cyc] = bus.dram_ready;
    obs_vld[cyc] = bus.dram_data_valid;
    obs_dat[cyc] = bus.dram_data_i;
    chk("ready", bus.dram_ready, m_rdy);
    chk("valid", bus.dram_data_valid, ev);
    chk("data", bus.dram_data_i, e);
    acc = 1'b0;
    if (rst) begin
      exp_dat.delete();
      busy_until = cyc + 1;
      due_at     = cyc + RP;
      wr2_pend   = 1'b0;
    end else begin
      if (wr2_pend) begin
        merge(wr2_idx, d, be);
        wr2_pend = 1'b0;
      end
      idx0 = int'({addr[AB-1:1], 1'b0});
      if (m_rdy && en) begin
        acc = 1'b1;
        if (rnw) begin
          exp_dat[cyc + LAT]     = mem_m[idx0];
          exp_dat[cyc + LAT + 1] = mem_m[idx0 + 1];
        end else begin
          merge(idx0, d, be);
          wr2_pend = 1'b1;
          wr2_idx  = idx0 + 1;
        end
        busy_until = cyc + 2;
        if (cyc + 1 >= due_at) begin
          busy_until = cyc + 2 + RCY;
          due_at     = cyc + 1 + RP;
        end
      end else if (m_rdy && cyc >= due_at) begin
        busy_until = cyc + 1 + RCY;
        due_at     = cyc + RP;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'($urandom()), $urandom(), rnd144(), 18'($urandom()), a);
  endtask

  task automatic rst_pulse(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b1, 1'($urandom()), 1'($urandom()), $urandom(), rnd144(), 18'($urandom()), a);
  endtask

  // Holds cmd_en with the same command until the model says it is accepted.
  task automatic do_cmd(input bit rnw, input logic [31:0] addr, input logic [143:0] d0, input logic [17:0] be0,
                        input logic [143:0] d1, input logic [17:0] be1, output int t);
    bit a;
    int tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 40) begin
      tick(1'b0, 1'b1, rnw, addr, d0, be0, a);
      tries++;
    end
    t = cyc - 1;
    if (!a) begin
      n_cmp++;
      n_bad++;
      $error("FAIL accept_budget: observed no acceptance in %0d cycles, required acceptance", tries);
    end
    tick(1'b0, 1'($urandom()), 1'($urandom()), $urandom(), d1, be1, a);
  endtask

  task automatic do_rd(input logic [31:0] addr, output int t);
    do_cmd(1'b1, addr, rnd144(), 18'($urandom()), rnd144(), 18'($urandom()), t);
  endtask

  task automatic check_burst(input string tag, input int t, input logic [143:0] b0, input logic [143:0] b1);
    chk({tag, "_v0"}, obs_vld[t + LAT], 1'b1);
    chk({tag, "_b0"}, obs_dat[t + LAT], b0);
    chk({tag, "_v1"}, obs_vld[t + LAT + 1], 1'b1);
    chk({tag, "_b1"}, obs_dat[t + LAT + 1], b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2, r;
    logic [143:0] da, db, ones_lo0;
    bus.dram_cmd_en      = 1'b0;
    bus.dram_rnw         = 1'b0;
    bus.dram_address     = '0;
    bus.dram_data_o      = '0;
    bus.dram_byte_enable = '0;

    rst_pulse(3);

    for (int b = 0; b < (1 << (AB - 1)); b++)
      do_cmd(1'b0, 32'(b) << 1, rnd144(), 18'h3FFFF, rnd144(), 18'h3FFFF, t);

    da = {36{4'hA}};
    db = {36{4'hB}};
    do_cmd(1'b0, 32'h10, da, 18'h3FFFF, db, 18'h3FFFF, t);
    do_rd(32'h10, t);
    idle(7);
    chk("r033_quiet_before", obs_vld[t + LAT - 1], 1'b0);
    check_burst("r033", t, da, db);

    ones_lo0 = {{136{1'b1}}, 8'h00};
    do_cmd(1'b0, 32'h20, '1, 18'h3FFFF, '1, 18'h3FFFF, t);
    do_cmd(1'b0, 32'h20, '0, 18'h00001, '0, 18'h00001, t);
    do_rd(32'h20, t);
    idle(7);
    check_burst("r034", t, ones_lo0, ones_lo0);

    do_cmd(1'b0, 32'hF000_0203, {9{16'h1234}}, 18'h3FFFF, {9{16'hBEEF}}, 18'h3FFFF, t);
    do_rd(32'h0000_0002, t);
    idle(7);
    check_burst("r038_alias", t, {9{16'h1234}}, {9{16'hBEEF}});

    do_cmd(1'b0, 32'h40, {18{8'h11}}, 18'h3FFFF, {18{8'h22}}, 18'h3FFFF, t);
    do_rd(32'h40, t1);
    do_cmd(1'b0, 32'h40, {18{8'h33}}, 18'h3FFFF, {18{8'h44}}, 18'h3FFFF, t);
    do_rd(32'h40, t2);
    idle(7);
    check_burst("r027_old", t1, {18{8'h11}}, {18{8'h22}});
    check_burst("r027_new", t2, {18{8'h33}}, {18{8'h44}});

    rst_pulse(1);
    r = cyc;
    for (int k = 0; k < 8; k++) do_rd($urandom(), t);
    idle(8);
    for (int k = 0; k < 16; k++) begin
      chk("r035_ready", obs_rdy[r + k], 1'((k % 2) == 0));
      chk("r035_valid", obs_vld[r + LAT + k], 1'b1);
    end
    chk("r035_gap_before", obs_vld[r + LAT - 1], 1'b0);
    chk("r035_gap_after", obs_vld[r + LAT + 16], 1'b0);

    rst_pulse(1);
    r = cyc;
    idle(22);
    chk("r036_idle_due", obs_rdy[r + RP - 1], 1'b1);
    for (int k = 0; k < RCY; k++) chk("r036_stall", obs_rdy[r + RP + k], 1'b0);
    chk("r036_resume", obs_rdy[r + RP + RCY], 1'b1);

    rst_pulse(1);
    r = cyc;
    idle(RP - 1);
    do_rd(32'h10, t);
    idle(7);
    chk("r036_collide_ready", obs_rdy[r + RP - 1], 1'b1);
    for (int k = 0; k <= RCY; k++) chk("r036_deferred_stall", obs_rdy[r + RP + k], 1'b0);
    chk("r036_deferred_resume", obs_rdy[r + RP + RCY + 1], 1'b1);
    check_burst("r036_collide_data", t, da, db);

    for (int k = 0; k < 40; k++) do_cmd(1'($urandom()), $urandom(), rnd144(), 18'($urandom()), rnd144(), 18'($urandom()), t);
    idle(8);

    do_rd(32'h10, t);
    rst_pulse(1);
    idle(10);
    for (int k = 2; k <= 12; k++) chk("r037_no_valid", obs_vld[t + k], 1'b0);
    chk("r037_ready_after", obs_rdy[t + 3], 1'b1);
    do_rd(32'h10, t);
    idle(7);
    check_burst("r037_mem_kept", t, da, db);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 0));
      do_cmd(1'($urandom()), $urandom(), rnd144(),
             ($urandom_range(1, 0) == 0) ? 18'h3FFFF : 18'($urandom()),
             rnd144(), 18'($urandom()), t);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
